// File: rtl/bram_scan_sequencer.sv
// Purpose: sole master of the pattern ROM address port; walks it and streams each word out on valid/ready.
// Latency: first word valid 2 cycles after the start-sampling edge (READ_LATENCY=1); a word every 3 + PACE_CYCLES cycles.
// Backpressure: the presented word is held stable until out_ready, and no new ROM read is issued meanwhile.
module bram_scan_sequencer #(
    parameter int DEPTH        = 10,
    parameter int ADDR_W       = 4,
    parameter int DATA_W       = 4,
    parameter int READ_LATENCY = 1,
    parameter int PACE_CYCLES  = 0,
    parameter int CNT_W        = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              loop_en,
    input  logic              abort,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  xfer_count
);

    // Counter widths never drop to zero, even when pacing is disabled.
    localparam int LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY + 1) : 1;
    localparam int PW = (PACE_CYCLES  > 1) ? $clog2(PACE_CYCLES + 1)  : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_PRESENT,
        S_GAP,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_index;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_out_data;
    logic [ADDR_W-1:0] r_out_index;
    logic              r_out_valid;
    logic [CNT_W-1:0]  r_xfer_count;
    logic [LW-1:0]     r_lat;
    logic [PW-1:0]     r_pace;
    logic              w_abort;
    logic              w_xfer;
    logic              w_last;
    logic              w_busy;
    logic              w_done;

    // Abort only matters outside IDLE; it also cancels a same-cycle transfer.
    assign w_abort = abort && (r_state != S_IDLE);
    assign w_xfer  = r_out_valid && out_ready && !w_abort;
    assign w_last  = (r_index == ADDR_W'(DEPTH - 1));

    assign mem_addr   = r_mem_addr;
    assign out_data   = r_out_data;
    assign out_index  = r_out_index;
    assign out_valid  = r_out_valid;
    assign xfer_count = r_xfer_count;
    assign busy       = w_busy;
    assign done       = w_done;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode plus state-derived status outputs.
    always_comb begin
        w_next = r_state;
        w_busy = (r_state != S_IDLE);
        w_done = (r_state == S_DONE);
        if (w_abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    if (start) w_next = S_ISSUE;
                S_ISSUE:   w_next = S_WAIT;
                S_WAIT:    if (r_lat == LW'(1)) w_next = S_PRESENT;
                S_PRESENT: begin
                    if (w_xfer) begin
                        if (w_last && !loop_en) begin
                            w_next = S_DONE;
                        end else if (PACE_CYCLES > 0) begin
                            w_next = S_GAP;
                        end else begin
                            w_next = S_ISSUE;
                        end
                    end
                end
                S_GAP:     if (r_pace == PW'(1)) w_next = S_ISSUE;
                S_DONE:    w_next = S_IDLE;
                default:   w_next = S_IDLE;
            endcase
        end
    end

    // Datapath: address walk, ROM capture, output word, transfer counter, latency/pace timers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_index      <= '0;
            r_mem_addr   <= '0;
            r_out_data   <= '0;
            r_out_index  <= '0;
            r_out_valid  <= 1'b0;
            r_xfer_count <= '0;
            r_lat        <= '0;
            r_pace       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_index      <= '0;
                        r_mem_addr   <= '0;
                        r_xfer_count <= '0;
                    end
                end
                S_ISSUE: begin
                    r_lat <= LW'(READ_LATENCY);
                end
                S_WAIT: begin
                    r_lat <= r_lat - 1'b1;
                    if (r_lat == LW'(1)) begin
                        r_out_data  <= mem_data;
                        r_out_index <= r_index;
                        r_out_valid <= 1'b1;
                    end
                end
                S_PRESENT: begin
                    if (w_xfer) begin
                        r_out_valid <= 1'b0;
                        r_pace      <= PW'(PACE_CYCLES);
                        if (r_xfer_count != {CNT_W{1'b1}}) begin
                            r_xfer_count <= r_xfer_count + 1'b1;
                        end
                        if (!w_last) begin
                            r_index    <= r_index + 1'b1;
                            r_mem_addr <= r_index + 1'b1;
                        end else if (loop_en) begin
                            r_index    <= '0;
                            r_mem_addr <= '0;
                        end
                    end
                end
                S_GAP: begin
                    r_pace <= r_pace - 1'b1;
                end
                S_DONE: begin
                    r_index    <= '0;
                    r_mem_addr <= '0;
                end
                default: begin
                end
            endcase
            // Abort overrides whatever the state above scheduled; the count is kept.
            if (w_abort) begin
                r_out_valid <= 1'b0;
                r_mem_addr  <= '0;
                r_index     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bram_scan_sequencer.sv
// Purpose: self-checking bench for bram_scan_sequencer; one DUT with no pacing, one with PACE_CYCLES=2.
// Latency: the ROM model is a single registered read stage, matching READ_LATENCY=1.
// Backpressure: out_ready per DUT is driven from the stimulus; a monitor checks words are held while stalled.
module tb_bram_scan_sequencer;

    localparam int DEPTH = 10;

    typedef struct packed {
        logic [3:0] idx;
        logic [3:0] dat;
        logic [7:0] gap;
    } item_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_s     [2];
    logic       loop_en_s   [2];
    logic       abort_s     [2];
    logic       out_ready_s [2];
    logic [3:0] mem_addr_s  [2];
    logic [3:0] mem_data_s  [2];
    logic [3:0] out_data_s  [2];
    logic [3:0] out_index_s [2];
    logic       out_valid_s [2];
    logic       busy_s      [2];
    logic       done_s      [2];
    logic [7:0] xfer_cnt_s  [2];

    logic [3:0] rom [DEPTH] = '{4'hA, 4'hC, 4'hF, 4'h1, 4'h6, 4'h8, 4'h5, 4'h3, 4'hE, 4'h2};

    item_t q0[$];
    item_t q1[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    cyc   = 0;
    int    last_x [2];
    int    n_xfer [2];
    int    n_done [2];
    logic       pend     [2];
    logic [3:0] pend_dat [2];
    logic [3:0] pend_idx [2];
    int    nd;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    bram_scan_sequencer #(.PACE_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .loop_en(loop_en_s[0]), .abort(abort_s[0]),
        .mem_addr(mem_addr_s[0]), .mem_data(mem_data_s[0]), .out_data(out_data_s[0]),
        .out_index(out_index_s[0]), .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]),
        .busy(busy_s[0]), .done(done_s[0]), .xfer_count(xfer_cnt_s[0])
    );

    bram_scan_sequencer #(.PACE_CYCLES(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .loop_en(loop_en_s[1]), .abort(abort_s[1]),
        .mem_addr(mem_addr_s[1]), .mem_data(mem_data_s[1]), .out_data(out_data_s[1]),
        .out_index(out_index_s[1]), .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]),
        .busy(busy_s[1]), .done(done_s[1]), .xfer_count(xfer_cnt_s[1])
    );

    // Registered-read ROM for each DUT.
    always @(posedge clk) begin
        mem_data_s[0] <= rom[mem_addr_s[0]];
        mem_data_s[1] <= rom[mem_addr_s[1]];
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_one(input int k, input int idx, input int gap);
        item_t e;
        e.idx = 4'(idx);
        e.dat = rom[idx];
        e.gap = 8'(gap);
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic push_scan(input int k, input int first, input int n, input int first_gap, input int gap);
        for (int i = 0; i < n; i++) push_one(k, (first + i) % DEPTH, (i == 0) ? first_gap : gap);
    endtask

    // Pulse start for one cycle and check the first-word timing.
    task automatic start_scan(input int k);
        @(posedge clk); #1;
        start_s[k] = 1'b1;
        @(posedge clk); #1;
        start_s[k] = 1'b0;
        check_val("start_busy", busy_s[k], 1);
        check_val("start_cnt", xfer_cnt_s[k], 0);
        check_val("start_addr", mem_addr_s[k], 0);
        @(posedge clk); #1;
        check_val("vld_early", out_valid_s[k], 0);
        @(posedge clk); #1;
        check_val("vld_first", out_valid_s[k], 1);
    endtask

    task automatic wait_idx(input int k, input int idx);
        int t = 0;
        while (!(out_valid_s[k] && out_index_s[k] == 4'(idx)) && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        check_val("wait_idx_timeout", int'(t < 200), 1);
    endtask

    task automatic wait_done(input int k);
        int t = 0;
        while (!done_s[k] && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        check_val("wait_done_timeout", int'(t < 300), 1);
    endtask

    task automatic wait_xfers(input int k, input int n);
        int t = 0;
        while (n_xfer[k] < n && t < 400) begin
            @(posedge clk); #1;
            t++;
        end
        check_val("wait_xfer_timeout", int'(t < 400), 1);
    endtask

    // Monitor: scoreboard pop on each handshake, hold-stable and address-range checks.
    always @(negedge clk) begin : mon
        item_t e;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                pend[k] = 1'b0;
            end else begin
                check_val("addr_range", int'(mem_addr_s[k] < 4'd10), 1);
                if (done_s[k]) n_done[k]++;
                if (pend[k]) begin
                    check_val("hold_vld", out_valid_s[k], 1);
                    check_val("hold_dat", out_data_s[k], pend_dat[k]);
                    check_val("hold_idx", out_index_s[k], pend_idx[k]);
                end
                if (out_valid_s[k] && out_ready_s[k] && !abort_s[k]) begin
                    if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                        check_val("sb_extra_word", 1, 0);
                    end else begin
                        if (k == 0) e = q0.pop_front();
                        else        e = q1.pop_front();
                        check_val("sb_idx", out_index_s[k], e.idx);
                        check_val("sb_dat", out_data_s[k], e.dat);
                        if (e.gap != 8'd0) check_val("sb_gap", cyc - last_x[k], e.gap);
                    end
                    last_x[k] = cyc;
                    n_xfer[k]++;
                end
                pend[k]     = out_valid_s[k] && !out_ready_s[k] && !abort_s[k];
                pend_dat[k] = out_data_s[k];
                pend_idx[k] = out_index_s[k];
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion expected finish before 100us");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            start_s[k] = 1'b0; loop_en_s[k] = 1'b0; abort_s[k] = 1'b0; out_ready_s[k] = 1'b0;
            last_x[k] = 0; n_xfer[k] = 0; n_done[k] = 0; pend[k] = 1'b0;
            pend_dat[k] = '0; pend_idx[k] = '0;
        end
        #22;
        check_val("rst_addr", mem_addr_s[0], 0);
        check_val("rst_data", out_data_s[0], 0);
        check_val("rst_index", out_index_s[0], 0);
        check_val("rst_valid", out_valid_s[0], 0);
        check_val("rst_busy", busy_s[0], 0);
        check_val("rst_done", done_s[0], 0);
        check_val("rst_cnt", xfer_cnt_s[0], 0);
        check_val("rst_busy1", busy_s[1], 0);
        rst_n = 1'b1;

        // One-shot scan at full rate.
        out_ready_s[0] = 1'b1;
        push_scan(0, 0, 10, 0, 3);
        start_scan(0);
        wait_done(0);
        check_val("done_time", cyc, last_x[0] + 1);
        check_val("done_cnt", xfer_cnt_s[0], 10);
        check_val("done_busy", busy_s[0], 1);
        @(posedge clk); #1;
        check_val("post_done", done_s[0], 0);
        check_val("post_busy", busy_s[0], 0);
        check_val("post_addr", mem_addr_s[0], 0);

        // Backpressure on index 2, with a start pulse that must be ignored.
        push_scan(0, 0, 2, 0, 3);
        push_scan(0, 2, 1, 8, 8);
        push_scan(0, 3, 7, 3, 3);
        start_scan(0);
        wait_idx(0, 2);
        out_ready_s[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            start_s[0] = (i == 1);
            check_val("bp_addr", mem_addr_s[0], 2);
        end
        start_s[0]     = 1'b0;
        out_ready_s[0] = 1'b1;
        wait_done(0);
        check_val("bp_cnt", xfer_cnt_s[0], 10);
        @(posedge clk); #1;

        // Abort during WAIT of index 4.
        push_scan(0, 0, 4, 0, 3);
        start_scan(0);
        wait_idx(0, 3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        abort_s[0] = 1'b1;
        nd = n_done[0];
        @(posedge clk); #1;
        abort_s[0] = 1'b0;
        check_val("abort_valid", out_valid_s[0], 0);
        check_val("abort_busy", busy_s[0], 0);
        check_val("abort_cnt", xfer_cnt_s[0], 4);
        check_val("abort_addr", mem_addr_s[0], 0);
        repeat (4) @(posedge clk);
        #1;
        check_val("abort_idle", busy_s[0], 0);
        check_val("abort_nodone", n_done[0], nd);

        // Restart from 0, then abort against a simultaneous transfer of index 1.
        push_scan(0, 0, 1, 0, 3);
        start_scan(0);
        wait_idx(0, 1);
        abort_s[0] = 1'b1;
        @(posedge clk); #1;
        abort_s[0] = 1'b0;
        check_val("abpri_cnt", xfer_cnt_s[0], 1);
        check_val("abpri_valid", out_valid_s[0], 0);
        check_val("abpri_busy", busy_s[0], 0);

        // Looping scan with pacing on the second DUT.
        out_ready_s[1] = 1'b1;
        loop_en_s[1]   = 1'b1;
        push_scan(1, 0, 12, 0, 5);
        start_scan(1);
        wait_xfers(1, 12);
        check_val("loop_cnt", xfer_cnt_s[1], 12);
        check_val("loop_busy", busy_s[1], 1);
        abort_s[1] = 1'b1;
        @(posedge clk); #1;
        abort_s[1] = 1'b0;
        check_val("loop_stop", busy_s[1], 0);
        check_val("loop_nodone", n_done[1], 0);

        // Asynchronous reset while a word is presented.
        out_ready_s[0] = 1'b0;
        start_scan(0);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_valid", out_valid_s[0], 0);
        check_val("arst_busy", busy_s[0], 0);
        check_val("arst_addr", mem_addr_s[0], 0);
        check_val("arst_data", out_data_s[0], 0);
        check_val("arst_index", out_index_s[0], 0);
        check_val("arst_cnt", xfer_cnt_s[0], 0);
        check_val("arst_done", done_s[0], 0);
        #10;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("arst_idle", busy_s[0], 0);
        check_val("arst_novld", out_valid_s[0], 0);
        check_val("total_done0", n_done[0], 2);

        check_val("q0_empty", q0.size(), 0);
        check_val("q1_empty", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
